div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Run/config controller for the pc1 clock-divider path.
//  - Produces a programmable-ratio clock-enable pulse (o_TICK) and a divided clock (o_CLK).
//  - Accepts divisor changes over a valid/ready handshake.
//  - Applies a change only at a period boundary, so no runt periods occur.
//  - Sits between control logic (run control i_EN, divisor updates) and every consumer of the divided timebase.
// PARAMETERS
//  W        8    divisor/counter width; legal divisor 2..2^W-1
//  DEF_DIV  10   divisor loaded at reset; must be >= 2
//  PCNT_W   16   width of the completed-period counter o_PERIODS
// PORTS
//  i_CLK        in   1       single clock, rising edge
//  i_RST        in   1       reset, synchronous, active-high
//  i_EN         in   1       run control: 1 = divide, 0 = idle
//  i_CFG_VALID  in   1       divisor update request
//  i_CFG_DIV    in   W       requested divisor
//  o_CFG_READY  out  1       update can be accepted this cycle
//  o_TICK       out  1       1-cycle pulse on the last cycle of each period
//  o_CLK        out  1       divided clock, registered
//  o_BUSY       out  1       state != IDLE
//  o_PERIODS    out  PCNT_W  completed periods since reset; wraps modulo 2^PCNT_W
// BEHAVIOUR
//  Reset (i_RST=1 at an edge), with priority over all other inputs:
//   - state=IDLE, cnt=0, div_q=DEF_DIV, pend_q discarded.
//   - o_CLK=0, o_TICK=0, o_BUSY=0, o_PERIODS=0, o_CFG_READY=1.
//  Handshake:
//   - Transfer = i_CFG_VALID & o_CFG_READY at a rising edge.
//   - Divisor clamp: 0 or 1 -> 2.
//   - o_CFG_READY=1 in IDLE and RUN, 0 in SWITCH.
//  States:
//   - IDLE: cnt held at 0; o_CLK=0; o_TICK=0.
//     * Transfer -> div_q <= clamped value, effective immediately.
//     * i_EN=1 -> RUN, cnt=0 on the next cycle.
//   - RUN: cnt increments each cycle; cnt==div_q-1 -> cnt<=0, o_PERIODS+1.
//     * Transfer -> pend_q <= clamped value; -> SWITCH.
//     * A transfer in the same cycle as o_TICK is still pending; it applies at the NEXT wrap.
//   - SWITCH: counts like RUN; at the wrap: div_q <= pend_q, -> RUN.
//     * First period after the wrap uses the new divisor.
//   - i_EN=0 in RUN or SWITCH: -> IDLE next cycle; cnt <= 0; partial period not counted.
//     * In SWITCH, pend_q is first copied to div_q.
//  Outputs:
//   - o_TICK = (state!=IDLE) & (cnt==div_q-1); decoded from registers only, no input->output path.
//   - o_CLK is registered; it shows the value of (cnt >= div_q>>1) from the previous cycle.
//     Low for floor(D/2) cycles, high for ceil(D/2) cycles; 1-cycle latency to o_TICK.
//  Width rules:
//   - cnt and div_q are W bits; compare div_q-1 in W bits (div_q >= 2, so no underflow).
//   - o_PERIODS wraps silently.
//  Reset mid-operation (any state): full reset values; a pending divisor is lost.
// STRUCTURE
//  - div_ctrl_pkg.vh: state localparams (IDLE=2'd0, RUN=2'd1, SWITCH=2'd2) and MIN_DIV=2.
//    Shared with the pc1 wrapper and the bench.
//  - One sub-module, div_counter: cnt register, wrap compare, o_CLK phase flop.
//    Inputs: run, div; outputs: wrap, phase.
//  - div_ctrl holds the FSM, handshake, clamp, pend_q and o_PERIODS.
// TESTING
//  1 Reset: hold i_RST 2 cycles at any state -> o_CLK=0, o_TICK=0, o_BUSY=0, o_PERIODS=0, o_CFG_READY=1.
//  2 Basic run: cfg DIV=4 in IDLE, i_EN=1 for 20 cycles
//    -> o_TICK every 4th cycle; o_CLK = 2 low / 2 high; o_PERIODS=5 after 5 ticks.
//  3 Retiming: in RUN with DIV=4, cfg DIV=6 at cnt=1 -> o_CFG_READY=0 until the wrap;
//    that period still lasts 4 cycles; then ticks every 6 cycles.
//    Repeat with the cfg transfer on the tick cycle -> one more 4-cycle period before 6.
//  4 Clamp: cfg DIV=0 and then DIV=1 -> ticks every 2 cycles; o_CLK toggles every cycle.
//  5 Stop: drop i_EN at cnt=2 of DIV=5 -> IDLE next cycle; no o_TICK; o_PERIODS unchanged;
//    re-enable -> first tick 5 cycles later.
//  6 Reset in SWITCH: pending DIV=9 over DEF_DIV=10, then assert i_RST
//    -> after reset and i_EN=1, ticks every 10 cycles.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
//   Shared constants for the pc1 clock-divider controller: FSM state encodings
//   and the smallest legal divisor. Imported by the RTL; the pc1 wrapper and
//   the bench may import it as well.
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  // FSM state encodings (kept as plain 2-bit constants for legacy tooling).
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  // Requested divisors below this value are raised to it.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_counter.sv
// -----------------------------------------------------------------------------
// div_counter
//   Period counter for the clock divider. Counts 0..div-1 while running,
//   flags the last cycle of each period and produces the registered phase
//   used as the divided clock.
//
// Ports
//   i_CLK    in   1  clock, rising edge
//   i_RST    in   1  synchronous active-high reset
//   i_run    in   1  controller is active (registered state != IDLE)
//   i_clr    in   1  stop request; clears the counter at the next edge
//   i_div    in   W  current divisor (registered, >= 2)
//   o_wrap   out  1  last cycle of the period (registers only)
//   o_phase  out  1  divided clock: previous cycle's (cnt >= div/2)
// -----------------------------------------------------------------------------
module div_counter #(
  parameter int W = 8
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_run,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_wrap,
  output logic         o_phase
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;
  logic [W-1:0] last_cnt;

  // i_div >= 2 always, so the subtraction cannot underflow.
  assign last_cnt = i_div - W'(1);
  assign o_wrap   = i_run & (cnt_q == last_cnt);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q + W'(1);
    phase_d = (cnt_q >= (i_div >> 1));
    if (!i_run || i_clr) begin
      // Idle, or stopping this cycle: counter parked at 0, clock held low.
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (o_wrap) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_q;

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Run/config controller for the pc1 clock-divider path. Produces a
//   programmable-ratio tick pulse and a divided clock. Divisor changes arrive
//   over a valid/ready handshake and take effect only at a period boundary,
//   so consumers never see a runt period.
//
// Ports
//   i_CLK        in   1       clock, rising edge
//   i_RST        in   1       synchronous active-high reset
//   i_EN         in   1       1 = divide, 0 = idle
//   i_CFG_VALID  in   1       divisor update request
//   i_CFG_DIV    in   W       requested divisor (0/1 are raised to 2)
//   o_CFG_READY  out  1       update accepted this cycle if valid
//   o_TICK       out  1       pulse on the last cycle of each period
//   o_CLK        out  1       divided clock, registered
//   o_BUSY       out  1       controller not idle
//   o_PERIODS    out  PCNT_W  completed periods since reset (wraps)
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_DIV = 10,
  parameter int PCNT_W  = 16
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_EN,
  input  logic              i_CFG_VALID,
  input  logic [W-1:0]      i_CFG_DIV,
  output logic              o_CFG_READY,
  output logic              o_TICK,
  output logic              o_CLK,
  output logic              o_BUSY,
  output logic [PCNT_W-1:0] o_PERIODS
);

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      div_q, div_d;
  logic [W-1:0]      pend_q, pend_d;
  logic [PCNT_W-1:0] periods_q, periods_d;

  logic              cfg_ready;
  logic              xfer;
  logic [W-1:0]      cfg_div_clamped;
  logic              run;
  logic              wrap;
  logic              phase;

  assign run             = (state_q != IDLE);
  assign cfg_ready       = (state_q != SWITCH);
  assign xfer            = i_CFG_VALID & cfg_ready;
  assign cfg_div_clamped = (i_CFG_DIV < W'(MIN_DIV)) ? W'(MIN_DIV) : i_CFG_DIV;

  div_counter #(
    .W (W)
  ) u_counter (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_run   (run),
    .i_clr   (~i_EN),
    .i_div   (div_q),
    .o_wrap  (wrap),
    .o_phase (phase)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pend_d    = pend_q;
    periods_d = periods_q;

    // A tick marks a completed period even if the run stops on that edge.
    if (wrap) begin
      periods_d = periods_q + PCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        // No period in flight, so a new divisor can apply at once.
        if (xfer) begin
          div_d = cfg_div_clamped;
        end
        if (i_EN) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!i_EN) begin
          state_d = IDLE;
          // Ready is high here, so an update may still be accepted; the run
          // is ending, so there is no boundary to wait for.
          if (xfer) begin
            div_d = cfg_div_clamped;
          end
        end else if (xfer) begin
          // Even when this is the tick cycle, the new value waits for the
          // following wrap: the boundary being crossed now was already
          // committed to the old divisor.
          pend_d  = cfg_div_clamped;
          state_d = SWITCH;
        end
      end

      SWITCH: begin
        if (!i_EN) begin
          div_d   = pend_q;
          state_d = IDLE;
        end else if (wrap) begin
          div_d   = pend_q;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      div_q     <= W'(DEF_DIV);
      pend_q    <= W'(DEF_DIV);
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      periods_q <= periods_d;
    end
  end

  assign o_CFG_READY = cfg_ready;
  assign o_TICK      = wrap;
  assign o_CLK       = phase;
  assign o_BUSY      = run;
  assign o_PERIODS   = periods_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//   Directed self-checking bench for div_ctrl. Each scenario task drives its
//   stimulus and compares outputs one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

  localparam int W      = 8;
  localparam int PCNT_W = 16;

  logic              i_CLK;
  logic              i_RST;
  logic              i_EN;
  logic              i_CFG_VALID;
  logic [W-1:0]      i_CFG_DIV;
  logic              o_CFG_READY;
  logic              o_TICK;
  logic              o_CLK;
  logic              o_BUSY;
  logic [PCNT_W-1:0] o_PERIODS;

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl #(
    .W       (W),
    .DEF_DIV (10),
    .PCNT_W  (PCNT_W)
  ) dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_EN        (i_EN),
    .i_CFG_VALID (i_CFG_VALID),
    .i_CFG_DIV   (i_CFG_DIV),
    .o_CFG_READY (o_CFG_READY),
    .o_TICK      (o_TICK),
    .o_CLK       (o_CLK),
    .o_BUSY      (o_BUSY),
    .o_PERIODS   (o_PERIODS)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Advance one clock; outputs are then stable for sampling.
  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_reset();
    i_RST       = 1'b1;
    i_EN        = 1'b0;
    i_CFG_VALID = 1'b0;
    step();
    step();
    i_RST = 1'b0;
  endtask

  task automatic cfg(input logic [W-1:0] d);
    i_CFG_VALID = 1'b1;
    i_CFG_DIV   = d;
    step();
    i_CFG_VALID = 1'b0;
  endtask

  task automatic test_reset();
    i_RST = 1'b1; i_EN = 1'b0; i_CFG_VALID = 1'b0; i_CFG_DIV = '0;
    step();
    step();
    n_checks++; if (o_CLK !== 1'b0) begin n_fail++; $display("FAIL reset_clk got %0b want 0", o_CLK); end
    n_checks++; if (o_TICK !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0b want 0", o_TICK); end
    n_checks++; if (o_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", o_BUSY); end
    n_checks++; if (o_PERIODS !== 16'd0) begin n_fail++; $display("FAIL reset_periods got %0d want 0", o_PERIODS); end
    n_checks++; if (o_CFG_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", o_CFG_READY); end
    i_RST = 1'b0;
  endtask

  task automatic test_basic_run();
    logic exp_tick, exp_clk;
    do_reset();
    cfg(8'd4);
    i_EN = 1'b1;
    step();
    for (int j = 0; j < 20; j++) begin
      exp_tick = (j % 4 == 3);
      exp_clk  = (j != 0) && (((j - 1) % 4) >= 2);
      n_checks++; if (o_TICK !== exp_tick) begin n_fail++; $display("FAIL basic_tick j=%0d got %0b want %0b", j, o_TICK, exp_tick); end
      n_checks++; if (o_CLK !== exp_clk) begin n_fail++; $display("FAIL basic_clk j=%0d got %0b want %0b", j, o_CLK, exp_clk); end
      step();
    end
    n_checks++; if (o_PERIODS !== 16'd5) begin n_fail++; $display("FAIL basic_periods got %0d want 5", o_PERIODS); end
    n_checks++; if (o_BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b want 1", o_BUSY); end
  endtask

  task automatic test_retiming();
    // Update at cnt=1: current period still 4 cycles, then 6.
    do_reset();
    cfg(8'd4);
    i_EN = 1'b1;
    step();
    step();
    n_checks++; if (o_CFG_READY !== 1'b1) begin n_fail++; $display("FAIL retime_ready_run got %0b want 1", o_CFG_READY); end
    cfg(8'd6);
    for (int k = 2; k < 4; k++) begin
      n_checks++; if (o_CFG_READY !== 1'b0) begin n_fail++; $display("FAIL retime_ready_sw k=%0d got %0b want 0", k, o_CFG_READY); end
      n_checks++; if (o_TICK !== (k == 3)) begin n_fail++; $display("FAIL retime_old_tick k=%0d got %0b want %0b", k, o_TICK, (k == 3)); end
      step();
    end
    for (int j = 0; j < 12; j++) begin
      if (j == 0) begin
        n_checks++; if (o_CFG_READY !== 1'b1) begin n_fail++; $display("FAIL retime_ready_back got %0b want 1", o_CFG_READY); end
      end
      n_checks++; if (o_TICK !== (j % 6 == 5)) begin n_fail++; $display("FAIL retime_new_tick j=%0d got %0b want %0b", j, o_TICK, (j % 6 == 5)); end
      step();
    end
    n_checks++; if (o_PERIODS !== 16'd3) begin n_fail++; $display("FAIL retime_periods got %0d want 3", o_PERIODS); end

    // Update on the tick cycle: one more full 4-cycle period first.
    do_reset();
    cfg(8'd4);
    i_EN = 1'b1;
    step();
    step();
    step();
    step();
    n_checks++; if (o_TICK !== 1'b1) begin n_fail++; $display("FAIL retime2_pre_tick got %0b want 1", o_TICK); end
    cfg(8'd6);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (o_CFG_READY !== 1'b0) begin n_fail++; $display("FAIL retime2_ready k=%0d got %0b want 0", k, o_CFG_READY); end
      n_checks++; if (o_TICK !== (k == 3)) begin n_fail++; $display("FAIL retime2_old_tick k=%0d got %0b want %0b", k, o_TICK, (k == 3)); end
      step();
    end
    for (int j = 0; j < 12; j++) begin
      n_checks++; if (o_TICK !== (j % 6 == 5)) begin n_fail++; $display("FAIL retime2_new_tick j=%0d got %0b want %0b", j, o_TICK, (j % 6 == 5)); end
      step();
    end
  endtask

  task automatic test_clamp();
    logic [W-1:0] req [2];
    logic         exp_clk;
    req[0] = 8'd0;
    req[1] = 8'd1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      cfg(req[r]);
      i_EN = 1'b1;
      step();
      for (int j = 0; j < 8; j++) begin
        exp_clk = (j != 0) && (j % 2 == 0);
        n_checks++; if (o_TICK !== (j % 2 == 1)) begin n_fail++; $display("FAIL clamp%0d_tick j=%0d got %0b want %0b", r, j, o_TICK, (j % 2 == 1)); end
        n_checks++; if (o_CLK !== exp_clk) begin n_fail++; $display("FAIL clamp%0d_clk j=%0d got %0b want %0b", r, j, o_CLK, exp_clk); end
        step();
      end
      i_EN = 1'b0;
      step();
    end
  endtask

  task automatic test_stop();
    do_reset();
    cfg(8'd5);
    i_EN = 1'b1;
    step();
    step();
    step();
    i_EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (o_BUSY !== 1'b0) begin n_fail++; $display("FAIL stop_busy k=%0d got %0b want 0", k, o_BUSY); end
      n_checks++; if (o_TICK !== 1'b0) begin n_fail++; $display("FAIL stop_tick k=%0d got %0b want 0", k, o_TICK); end
      n_checks++; if (o_CLK !== 1'b0) begin n_fail++; $display("FAIL stop_clk k=%0d got %0b want 0", k, o_CLK); end
      n_checks++; if (o_PERIODS !== 16'd0) begin n_fail++; $display("FAIL stop_periods k=%0d got %0d want 0", k, o_PERIODS); end
    end
    i_EN = 1'b1;
    step();
    for (int j = 0; j < 6; j++) begin
      n_checks++; if (o_TICK !== (j == 4)) begin n_fail++; $display("FAIL restart_tick j=%0d got %0b want %0b", j, o_TICK, (j == 4)); end
      step();
    end
    n_checks++; if (o_PERIODS !== 16'd1) begin n_fail++; $display("FAIL restart_periods got %0d want 1", o_PERIODS); end
  endtask

  task automatic test_reset_in_switch();
    do_reset();
    i_EN = 1'b1;
    step();
    step();
    cfg(8'd9);
    n_checks++; if (o_CFG_READY !== 1'b0) begin n_fail++; $display("FAIL rsw_ready_sw got %0b want 0", o_CFG_READY); end
    i_RST = 1'b1;
    i_EN  = 1'b0;
    step();
    step();
    n_checks++; if (o_BUSY !== 1'b0) begin n_fail++; $display("FAIL rsw_busy got %0b want 0", o_BUSY); end
    n_checks++; if (o_CFG_READY !== 1'b1) begin n_fail++; $display("FAIL rsw_ready got %0b want 1", o_CFG_READY); end
    n_checks++; if (o_CLK !== 1'b0) begin n_fail++; $display("FAIL rsw_clk got %0b want 0", o_CLK); end
    n_checks++; if (o_PERIODS !== 16'd0) begin n_fail++; $display("FAIL rsw_periods got %0d want 0", o_PERIODS); end
    i_RST = 1'b0;
    i_EN  = 1'b1;
    step();
    for (int j = 0; j < 20; j++) begin
      n_checks++; if (o_TICK !== (j % 10 == 9)) begin n_fail++; $display("FAIL rsw_tick j=%0d got %0b want %0b", j, o_TICK, (j % 10 == 9)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_retiming();
    test_clamp();
    test_stop();
    test_reset_in_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
